// File: rtl/helix_thought_serializer.sv
// Buffers wide thought words in a DEPTH-entry FIFO; each word leaves as LSB-first OUT_W beats, beat 0 one cycle after push.
// Backpressure: thought_ready drops when full (reopens the cycle after the last beat pops); out_* hold while out_ready=0.
module helix_thought_serializer #(
   parameter int THOUGHT_W = 64,
   parameter int OUT_W     = 16,
   parameter int DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       thought_valid,
   output logic                       thought_ready,
   input  logic [THOUGHT_W-1:0]       thought_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_last,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [15:0]                words_done
);
   localparam int BEATS = THOUGHT_W / OUT_W;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [THOUGHT_W-1:0] mem_q [DEPTH];
   logic [THOUGHT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [15:0]          words_done_q, words_done_d;
   logic [THOUGHT_W-1:0] head;
   logic                 is_last;
   logic                 push;
   logic                 beat;
   logic                 pop;

   // Both handshakes qualify on !flush, so a flush cycle never moves data.
   assign thought_ready = (count_q < CNT_W'(DEPTH)) && !flush;
   assign out_valid     = (count_q != '0) && !flush;
   assign head          = mem_q[rd_ptr_q];
   assign is_last       = (idx_q == IDX_W'(BEATS - 1));
   assign out_last      = out_valid && is_last;
   assign push          = thought_valid && thought_ready;
   assign beat          = out_valid && out_ready;
   assign pop           = beat && is_last;
   assign fifo_count    = count_q;
   assign words_done    = words_done_q;

   always_comb begin
      out_data = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (out_valid && (idx_q == IDX_W'(b))) begin
            out_data = head[b*OUT_W +: OUT_W];
         end
      end
   end

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      idx_d        = idx_q;
      words_done_d = words_done_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         idx_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = thought_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (beat) begin
            if (is_last) begin
               idx_d        = '0;
               rd_ptr_d     = rd_ptr_q + PTR_W'(1);
               words_done_d = words_done_q + 16'd1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         idx_q        <= '0;
         words_done_q <= '0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         idx_q        <= idx_d;
         words_done_q <= words_done_d;
      end
   end
endmodule

// File: tb/tb_helix_thought_serializer.sv
// Bench for helix_thought_serializer: word-queue reference model checked every cycle,
// plus a one-beat-per-word instance used for the words_done wrap.
module tb_helix_thought_serializer;
   localparam int DEPTH = 4;
   localparam int BEATS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tv = 1'b0;
   logic        tr;
   logic [63:0] td = '0;
   logic        flush = 1'b0;
   logic        ov;
   logic        ordy = 1'b0;
   logic [15:0] od;
   logic        ol;
   logic [2:0]  fc;
   logic [15:0] wd;

   logic        tv2 = 1'b0;
   logic        tr2;
   logic [63:0] td2 = '0;
   logic        flush2 = 1'b0;
   logic        ov2;
   logic        or2 = 1'b0;
   logic [63:0] od2;
   logic        ol2;
   logic [2:0]  fc2;
   logic [15:0] wd2;

   always #5 clk = ~clk;

   helix_thought_serializer #(.THOUGHT_W(64), .OUT_W(16), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .thought_valid(tv), .thought_ready(tr), .thought_data(td),
      .flush(flush),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .out_last(ol),
      .fifo_count(fc), .words_done(wd)
   );

   helix_thought_serializer #(.THOUGHT_W(64), .OUT_W(64), .DEPTH(DEPTH)) u_wide (
      .clk(clk), .rst_n(rst_n),
      .thought_valid(tv2), .thought_ready(tr2), .thought_data(td2),
      .flush(flush2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_last(ol2),
      .fifo_count(fc2), .words_done(wd2)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: queue of whole words plus the beat offset into the head word.
   logic [63:0] mq[$];
   int          off = 0;
   int unsigned done_m = 0;
   logic        acc = 1'b0;
   logic        stall_prev = 1'b0;
   logic [16:0] held_prev = '0;

   task automatic step();
      logic [63:0] expd;
      @(negedge clk);
      if (flush) begin
         check_eq("flush_valid", 64'(ov), 64'd0);
         check_eq("flush_ready", 64'(tr), 64'd0);
         check_eq("flush_data", 64'({ol, od}), 64'd0);
         acc = 1'b0;
         mq.delete();
         off = 0;
         stall_prev = 1'b0;
      end else begin
         check_eq("count", 64'(fc), 64'(mq.size()));
         check_eq("ready", 64'(tr), 64'(mq.size() < DEPTH));
         check_eq("valid", 64'(ov), 64'(mq.size() != 0));
         check_eq("words_done", 64'(wd), 64'(done_m & 32'hffff));
         if (stall_prev) check_eq("stall_hold", 64'({ol, od}), 64'(held_prev));
         if (mq.size() != 0) begin
            expd = (mq[0] >> (16 * off)) & 64'hffff;
            check_eq("beat_data", 64'(od), expd);
            check_eq("beat_last", 64'(ol), 64'(off == BEATS - 1));
         end else begin
            check_eq("idle_data", 64'({ol, od}), 64'd0);
         end
         stall_prev = (mq.size() != 0) && !ordy;
         held_prev = {ol, od};
         acc = tv && (mq.size() < DEPTH);
         if (mq.size() != 0 && ordy) begin
            if (off == BEATS - 1) begin
               void'(mq.pop_front());
               off = 0;
               done_m++;
            end else begin
               off++;
            end
         end
         if (acc) mq.push_back(td);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] w, input int bound);
      tv = 1'b1;
      td = w;
      acc = 1'b0;
      for (int c = 0; c < bound && !acc; c++) step();
      check_eq("send_acc", 64'(acc), 64'd1);
      tv = 1'b0;
   endtask

   task automatic drain(input int bound);
      ordy = 1'b1;
      for (int c = 0; c < bound && mq.size() != 0; c++) step();
      step();
      check_eq("drain_count", 64'(fc), 64'd0);
   endtask

   initial begin
      int k;
      int n;
      int np;
      logic pushed;
      logic popped;

      // Reset state
      #2;
      check_eq("rst_count", 64'(fc), 64'd0);
      check_eq("rst_done", 64'(wd), 64'd0);
      check_eq("rst_valid", 64'(ov), 64'd0);
      check_eq("rst_last", 64'(ol), 64'd0);
      check_eq("rst_data", 64'(od), 64'd0);
      check_eq("rst_ready", 64'(tr), 64'd1);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single word, sink always ready
      ordy = 1'b1;
      send(64'h4444_3333_2222_1111, 4);
      for (int i = 0; i < BEATS; i++) step();
      check_eq("t1_done", 64'(wd), 64'd1);
      check_eq("t1_idle", 64'(ov), 64'd0);

      // 2: fill while stalled, 5th word waits for the first pop
      ordy = 1'b0;
      for (int i = 0; i < 4; i++) send({16'(i + 16'ha0), 16'(i + 16'hb0), 16'(i + 16'hc0), 16'(i + 16'hd0)}, 3);
      tv = 1'b1;
      td = 64'hfeed_beef_cafe_f00d;
      step();
      check_eq("t2_blocked", 64'(acc), 64'd0);
      check_eq("t2_full", 64'(fc), 64'd4);
      ordy = 1'b1;
      k = 0;
      while (k < 20) begin
         step();
         if (acc) break;
         k++;
      end
      check_eq("t2_accept_cycle", 64'(k), 64'd4);
      tv = 1'b0;
      drain(40);

      // 3: random traffic on both sides
      n = 0;
      tv = 1'b0;
      for (int c = 0; c < 8000 && (n < 200 || mq.size() != 0); c++) begin
         ordy = 1'($urandom_range(0, 1));
         if (!tv && n < 200 && $urandom_range(0, 3) != 0) begin
            tv = 1'b1;
            td = {$urandom, $urandom};
         end
         step();
         if (acc) begin
            n++;
            tv = 1'b0;
         end
      end
      check_eq("t3_words", 64'(n), 64'd200);
      drain(10);

      // 4: flush mid-word with a second word queued
      ordy = 1'b0;
      send(64'haaaa_aaa3_aaa2_aaa1, 3);
      send(64'hbbbb_bbb3_bbb2_bbb1, 3);
      ordy = 1'b1;
      step();
      step();
      flush = 1'b1;
      tv = 1'b1;
      td = 64'hdead_dead_dead_dead;
      step();
      flush = 1'b0;
      tv = 1'b0;
      check_eq("t4_count", 64'(fc), 64'd0);
      check_eq("t4_valid", 64'(ov), 64'd0);
      step();
      send(64'hcccc_ccc3_ccc2_ccc1, 3);
      check_eq("t4_c_beat0", 64'(od), 64'h0000_0000_0000_ccc1);
      drain(20);

      // 5: async reset mid-word
      ordy = 1'b0;
      for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 3);
      ordy = 1'b1;
      step();
      rst_n = 1'b0;
      #2;
      check_eq("t5_valid", 64'(ov), 64'd0);
      check_eq("t5_count", 64'(fc), 64'd0);
      check_eq("t5_done", 64'(wd), 64'd0);
      mq.delete();
      off = 0;
      done_m = 0;
      stall_prev = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(64'h1234_5678_9abc_def0, 3);
      send(64'h0fed_cba9_8765_4321, 3);
      drain(20);

      // 6: words_done wrap on one-beat words
      tv2 = 1'b1;
      or2 = 1'b1;
      td2 = '0;
      np = 0;
      for (int c = 0; c < 70000 && np < 65536; c++) begin
         @(negedge clk);
         pushed = tv2 && tr2;
         popped = ov2 && or2;
         if (popped && (np < 3 || np >= 65534)) begin
            check_eq("w_data", od2, 64'(np));
            check_eq("w_last", 64'(ol2), 64'd1);
         end
         @(posedge clk);
         #1;
         if (pushed) td2 = td2 + 64'd1;
         if (popped) begin
            np++;
            if (np < 3 || np == 65535 || np == 65536) check_eq("w_done", 64'(wd2), 64'(np & 32'hffff));
         end
      end
      check_eq("w_total", 64'(np), 64'd65536);
      tv2 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
